// File: rtl/matmul_sched.sv
// rtl/matmul_sched.sv - sequencing controller and two-way round-robin arbiter for the 3x3 systolic product unit
module matmul_sched #(
    parameter int RUN_CYCLES = 12,
    parameter int CLR_CYCLES = 1,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       sel,
    output logic [3:0] mm_state,
    output logic       cap,
    output logic [1:0] done,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] MM_IDLE  = 4'b0000;
    localparam logic [3:0] MM_CLEAR = 4'b0010;
    localparam logic [3:0] MM_RUN   = 4'b1001;

    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [3:0]       mm_q, mm_d;
    logic             cap_q, cap_d;
    logic [1:0]       done_q, done_d;
    logic             busy_q, busy_d;
    logic [1:0]       onehot_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                sel_d = 1'b0;
                if (req != 2'b00) state_d = S_ARB;
            end
            S_ARB: begin
                if (req == 2'b00) begin
                    state_d = S_IDLE;
                end else begin
                    // On a tie the requester not served last time wins.
                    sel_d   = (req == 2'b11) ? ~last_q : req[1];
                    last_d  = sel_d;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                sel_d   = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                sel_d   = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        onehot_d = sel_d ? 2'b10 : 2'b01;
        gnt_d    = 2'b00;
        mm_d     = MM_IDLE;
        cap_d    = 1'b0;
        done_d   = 2'b00;
        busy_d   = (state_d != S_IDLE);
        case (state_d)
            S_CLEAR: begin
                gnt_d = onehot_d;
                mm_d  = MM_CLEAR;
            end
            S_RUN: begin
                gnt_d = onehot_d;
                mm_d  = MM_RUN;
            end
            S_DONE: begin
                gnt_d  = onehot_d;
                cap_d  = 1'b1;
                done_d = onehot_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            gnt_q   <= 2'b00;
            mm_q    <= MM_IDLE;
            cap_q   <= 1'b0;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            mm_q    <= mm_d;
            cap_q   <= cap_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign mm_state = mm_q;
    assign cap      = cap_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: doc/matmul_sched.md
Name: matmul_sched

Overview:
- Sequencing controller and two-way arbiter for the 3x3 systolic matrix-product unit, which is driven by a 4-bit state code and produces its outputs 41-bit wide.
- Accepts product requests from two requesters: requester 0 is OBB axis rotation and requester 1 is the collision separating-axis test.
- Grants one requester at a time and steers the operand mux to it.
- Drives the clear and run state codes for fixed cycle counts, then pulses a result-capture strobe and a per-requester done.

Parameters:
- RUN_CYCLES, 12: cycles the run code (4'b1001) is held; covers load, 8 shift/accumulate steps, the divide/output step and the negedge index latency.
- CLR_CYCLES, 1: cycles the clear code (4'b0010) is held; also gives the operand mux one clock to settle before the run phase.
- CNT_W, 4: width of the phase counter; must satisfy 2^CNT_W > max(RUN_CYCLES, CLR_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  2  per-requester product request; level; held until the matching done.
- gnt  output  2  one-hot grant; asserted from arbitration through the DONE state inclusive.
- sel  output  1  operand mux select (index of the granted requester); held stable from arbitration through DONE.
- mm_state  output  4  state code to the product unit: 4'b0000 idle, 4'b0010 clear, 4'b1001 run.
- cap  output  1  one-cycle strobe; the result register captures v0..v8 on this cycle.
- done  output  2  one-cycle done pulse to the granted requester, coincident with cap.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Synchronous active-low reset:
  - rst_n sampled low at a clk rising edge forces state to IDLE.
  - Outputs: gnt=0, sel=0, mm_state=4'b0000, cap=0, done=0, busy=0.
  - Phase counter cleared; round-robin pointer last=1, so requester 0 wins first.
  - Reset mid-operation aborts immediately; no done is issued and the product unit returns to code 0000. Requesters re-request after reset.
- FSM states: IDLE, ARB, CLEAR, RUN, DONE. All outputs are registered.
- IDLE:
  - If req != 0, go to ARB.
  - Outputs: mm_state=0000, gnt=0.
- ARB (1 cycle):
  - Winner = the only requester if one is requesting.
  - If both are requesting, winner = ~last.
  - Set gnt=onehot(winner), sel=winner, last=winner; go to CLEAR.
  - If req has dropped to 0, return to IDLE with no grant.
- CLEAR:
  - mm_state=0010 for CLR_CYCLES cycles.
  - Counter counts 0..CLR_CYCLES-1, then go to RUN with the counter reset.
- RUN:
  - mm_state=1001 for exactly RUN_CYCLES cycles, then go to DONE.
- DONE (1 cycle):
  - cap=1, done[winner]=1, mm_state=0000.
  - Next state is IDLE; gnt and sel drop on the cycle after DONE.
- Fixed latency from ARB entry to the done pulse: 1 + CLR_CYCLES + RUN_CYCLES cycles, which is 14 with the defaults.
- A req deasserted after grant is ignored: the run completes and done is still pulsed.
- The grant is non-preemptive: a request arriving mid-operation waits.
- A requester that holds req through its done gets re-arbitrated on the next IDLE→ARB. It loses to the other requester if both are requesting (fairness).
- Back-to-back service gap: IDLE and ARB add 2 cycles between a done and the next CLEAR.
- Counter never wraps: the terminal-count compare is equality, and RUN_CYCLES must be ≥ 1.
- gnt is always one-hot or zero. done and cap are never high outside DONE.

Test Plan:
- Single request: reset, then req=01 held → gnt=01 and sel=0 one cycle after ARB entry; mm_state=0010 for 1 cycle, then 1001 for 12 cycles; cap=1 and done=01 exactly 14 cycles after ARB entry; busy low the cycle after.
- Simultaneous requests: req=11 from reset → requester 0 served first (done=01), then requester 1 (done=10) with a 2-cycle gap. With req=11 still held, the third service goes to requester 0.
- Product check: drive the unit with identity-times-B (B=1..9 scaled by 10) through the mux → at cap, v0..v8 = B/10 element-wise, with the sign preserved for negative entries.
- Request dropped: req=10 for 3 cycles then 00 → run completes; done=10 is still pulsed at cycle 14; controller returns to IDLE and stays there.
- Reset mid-RUN: assert rst_n=0 at RUN cycle 5 → next cycle mm_state=0000, gnt=0, no done. Release with req=01 → a full 14-cycle sequence with correct results.
- Glitch request: req=01 pulsed for exactly 1 cycle (high in IDLE, low in ARB) → no grant, mm_state stays 0000, busy returns low after 1 cycle.
